// File: rtl/unidad_de_busqueda_if.sv
// unidad_de_busqueda_if: fetch-stage bus linking HDU/ID/ROM to the fetch controller
interface unidad_de_busqueda_if #(parameter int ANCHO_PC = 10);
  logic stall;
  logic salto_tomado;
  logic [ANCHO_PC-1:0] destino_salto;
  logic [31:0] instruccion_mem;
  logic [ANCHO_PC-1:0] direccion;
  logic [31:0] instruccion_if;
  logic [ANCHO_PC-1:0] pc_if;
  logic [ANCHO_PC-1:0] pc_mas_uno;
  logic instr_valida;
  logic detenido;
  logic [31:0] instr_contadas;
  modport master (
    output stall, salto_tomado, destino_salto, instruccion_mem,
    input direccion, instruccion_if, pc_if, pc_mas_uno, instr_valida, detenido, instr_contadas
  );
  modport slave (
    input stall, salto_tomado, destino_salto, instruccion_mem,
    output direccion, instruccion_if, pc_if, pc_mas_uno, instr_valida, detenido, instr_contadas
  );
endinterface

// File: rtl/unidad_de_busqueda.sv
// unidad_de_busqueda: fetch-stage controller owning the PC and feeding IF/ID
module unidad_de_busqueda #(
  parameter int ANCHO_PC = 10,
  parameter logic [ANCHO_PC-1:0] DIR_RESET = '0,
  parameter logic [31:0] INSTR_NOP = 32'h00000020,
  parameter logic [31:0] INSTR_HLT = 32'h00000000
) (
  input logic clk,
  input logic reset,
  unidad_de_busqueda_if.slave bus
);
  logic [ANCHO_PC-1:0] pc;
  logic [ANCHO_PC-1:0] pc_f;
  logic v_f;
  logic halt;
  logic [31:0] contadas;
  logic valida;
  // ROM address and IF/ID presentation; a stall re-reads pc_f so the ROM word holds
  always_comb begin
    valida = v_f & ~bus.salto_tomado & ~halt & ~reset;
    bus.direccion = reset ? DIR_RESET : (bus.stall & ~bus.salto_tomado) ? pc_f : pc;
    bus.instr_valida = valida;
    bus.instruccion_if = valida ? bus.instruccion_mem : INSTR_NOP;
    bus.pc_if = pc_f;
    bus.pc_mas_uno = pc_f + ANCHO_PC'(1);
    bus.detenido = halt;
    bus.instr_contadas = contadas;
  end
  // PC sequencing: reset > halt held > redirect > stall > halt detect > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= DIR_RESET;
      pc_f <= DIR_RESET;
      v_f <= 1'b0;
      halt <= 1'b0;
      contadas <= '0;
    end else if (!halt) begin
      if (valida && !bus.stall)
        contadas <= contadas + 32'd1;
      if (bus.salto_tomado) begin
        pc <= bus.destino_salto;
        pc_f <= pc;
        v_f <= 1'b0;
      end else if (!bus.stall) begin
        if (valida && bus.instruccion_mem == INSTR_HLT) begin
          halt <= 1'b1;
          v_f <= 1'b0;
        end else begin
          pc_f <= pc;
          pc <= pc + ANCHO_PC'(1);
          v_f <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_unidad_de_busqueda.sv
// tb_unidad_de_busqueda: randomized and directed checks of the fetch controller against a stream-level model
module tb_unidad_de_busqueda;
  localparam logic [31:0] NOP = 32'h00000020;
  localparam logic [31:0] HLT = 32'h00000000;
  logic clk;
  logic reset;
  logic [31:0] rom [1024];
  int n_cmp;
  int n_fail;
  // Stream model: m_pc is the next address to deliver, m_bub the bubbles before it appears
  logic [9:0] m_pc;
  int m_bub;
  bit m_halt;
  logic [31:0] m_cnt;
  bit p_r, p_s, p_j, started;
  logic [9:0] p_d;
  unidad_de_busqueda_if #(.ANCHO_PC(10)) bus ();
  unidad_de_busqueda dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Synchronous-read instruction ROM
  always @(posedge clk) bus.instruccion_mem <= rom[bus.direccion];
  task automatic model_edge();
    if (p_r) begin
      m_pc = 10'd0;
      m_bub = 1;
      m_halt = 1'b0;
      m_cnt = 32'd0;
    end else if (!m_halt && p_j) begin
      m_pc = p_d;
      m_bub = 1;
    end else if (!m_halt && !p_s && m_bub > 0) begin
      m_bub = 0;
    end else if (!m_halt && !p_s) begin
      m_cnt = m_cnt + 32'd1;
      if (rom[m_pc] == HLT) m_halt = 1'b1;
      else m_pc = m_pc + 10'd1;
    end
  endtask
  task automatic go(input bit r, input bit s, input bit j, input logic [9:0] d);
    if (started) model_edge();
    started = 1'b1;
    p_r = r;
    p_s = s;
    p_j = j;
    p_d = d;
    @(negedge clk);
    reset = r;
    bus.stall = s;
    bus.salto_tomado = j;
    bus.destino_salto = d;
    #1;
  endtask
  function automatic logic [85:0] obs();
    return {bus.instr_valida, bus.detenido, bus.instr_contadas,
            bus.instr_valida ? bus.pc_if : 10'd0, bus.instruccion_if,
            bus.instr_valida ? bus.pc_mas_uno : 10'd0};
  endfunction
  function automatic logic [85:0] expd();
    bit e_v;
    e_v = !m_halt && m_bub == 0 && !reset && !bus.salto_tomado;
    return {e_v, m_halt, m_cnt, e_v ? m_pc : 10'd0, e_v ? rom[m_pc] : NOP,
            e_v ? m_pc + 10'd1 : 10'd0};
  endfunction
  task automatic cargar_secuencia();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[0] = 32'h8C010001;
    rom[1] = 32'h00231020;
    rom[2] = 32'h00441820;
    rom[3] = 32'h00622020;
  endtask
  task automatic cargar_salto();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h10000000 + i;
    rom[0] = 32'h00210820;
    rom[1] = 32'h08000000;
  endtask
  task automatic test_reset();
    go(1, 0, 0, 10'd0);
    go(1, 0, 0, 10'd0);
    n_cmp++;
    if ({bus.instr_valida, bus.detenido, bus.instr_contadas, bus.direccion} !== {1'b0, 1'b0, 32'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b det=%b cnt=%0d dir=%0d want 0 0 0 0", bus.instr_valida, bus.detenido, bus.instr_contadas, bus.direccion);
    end
  endtask
  task automatic test_secuencia();
    logic [31:0] w [4];
    w = '{32'h8C010001, 32'h00231020, 32'h00441820, 32'h00622020};
    cargar_secuencia();
    go(1, 0, 0, 10'd0);
    for (int c = 0; c < 9; c++) begin
      go(0, 0, 0, 10'd0);
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL seq_model c%0d: got %h want %h", c, obs(), expd());
      end
      n_cmp++;
      if (c == 0 && bus.instr_valida !== 1'b0 ||
          c >= 1 && c <= 4 && {bus.instr_valida, bus.pc_if, bus.instruccion_if, bus.pc_mas_uno} !== {1'b1, 10'(c - 1), w[c - 1], 10'(c)} ||
          c == 5 && {bus.instr_valida, bus.pc_if, bus.instruccion_if} !== {1'b1, 10'd4, HLT} ||
          c >= 6 && {bus.detenido, bus.instr_valida, bus.instr_contadas} !== {1'b1, 1'b0, 32'd5}) begin
        n_fail++;
        $display("FAIL seq_fixed c%0d: got v=%b pc=%0d instr=%h pc1=%0d det=%b cnt=%0d", c, bus.instr_valida, bus.pc_if, bus.instruccion_if, bus.pc_mas_uno, bus.detenido, bus.instr_contadas);
      end
    end
  endtask
  task automatic test_stall();
    cargar_secuencia();
    go(1, 0, 0, 10'd0);
    go(0, 0, 0, 10'd0);
    go(0, 0, 0, 10'd0);
    for (int c = 2; c < 6; c++) begin
      go(0, c < 4, 0, 10'd0);
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL stall_model c%0d: got %h want %h", c, obs(), expd());
      end
      n_cmp++;
      if (c < 5 && {bus.instr_valida, bus.pc_if, bus.instruccion_if} !== {1'b1, 10'd1, 32'h00231020} ||
          c < 4 && bus.direccion !== 10'd1 ||
          c == 5 && {bus.instr_valida, bus.pc_if, bus.instr_contadas} !== {1'b1, 10'd2, 32'd2}) begin
        n_fail++;
        $display("FAIL stall_fixed c%0d: got v=%b pc=%0d instr=%h dir=%0d cnt=%0d", c, bus.instr_valida, bus.pc_if, bus.instruccion_if, bus.direccion, bus.instr_contadas);
      end
    end
  endtask
  task automatic test_salto();
    cargar_salto();
    go(1, 0, 0, 10'd0);
    for (int c = 0; c < 7; c++) begin
      go(0, 0, c == 3, 10'd0);
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL salto_model c%0d: got %h want %h", c, obs(), expd());
      end
      n_cmp++;
      if ((c == 3 || c == 4) && bus.instr_valida !== 1'b0 ||
          c == 5 && {bus.instr_valida, bus.pc_if, bus.instruccion_if} !== {1'b1, 10'd0, 32'h00210820}) begin
        n_fail++;
        $display("FAIL salto_fixed c%0d: got v=%b pc=%0d instr=%h", c, bus.instr_valida, bus.pc_if, bus.instruccion_if);
      end
    end
  endtask
  task automatic test_salto_stall();
    cargar_salto();
    go(1, 0, 0, 10'd0);
    for (int c = 0; c < 6; c++) begin
      go(0, c == 2, c == 2, 10'd3);
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL salto_stall_model c%0d: got %h want %h", c, obs(), expd());
      end
      n_cmp++;
      if (c == 2 && {bus.direccion, bus.instr_valida} !== {10'd2, 1'b0} ||
          c == 3 && {bus.direccion, bus.instr_valida} !== {10'd3, 1'b0} ||
          c == 4 && {bus.instr_valida, bus.pc_if, bus.instruccion_if} !== {1'b1, 10'd3, 32'h10000003}) begin
        n_fail++;
        $display("FAIL salto_stall_fixed c%0d: got dir=%0d v=%b pc=%0d instr=%h", c, bus.direccion, bus.instr_valida, bus.pc_if, bus.instruccion_if);
      end
    end
  endtask
  task automatic test_wrap();
    cargar_salto();
    go(1, 0, 0, 10'd0);
    for (int c = 0; c < 8; c++) begin
      go(0, 0, c == 2, 10'd1022);
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL wrap_model c%0d: got %h want %h", c, obs(), expd());
      end
      n_cmp++;
      if (c == 4 && {bus.instr_valida, bus.pc_if} !== {1'b1, 10'd1022} ||
          c == 5 && {bus.instr_valida, bus.pc_if, bus.pc_mas_uno} !== {1'b1, 10'd1023, 10'd0} ||
          c == 6 && {bus.instr_valida, bus.pc_if, bus.pc_mas_uno} !== {1'b1, 10'd0, 10'd1}) begin
        n_fail++;
        $display("FAIL wrap_fixed c%0d: got v=%b pc=%0d pc1=%0d", c, bus.instr_valida, bus.pc_if, bus.pc_mas_uno);
      end
    end
  endtask
  task automatic test_reset_mid();
    cargar_secuencia();
    go(1, 0, 0, 10'd0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 9; c++) begin
        go(0, k == 0 && c >= 2, 0, 10'd0);
        n_cmp++;
        if (obs() !== expd()) begin
          n_fail++;
          $display("FAIL rst_mid_run k%0d c%0d: got %h want %h", k, c, obs(), expd());
        end
      end
      go(1, k == 0, 0, 10'd0);
      go(0, 0, 0, 10'd0);
      n_cmp++;
      if ({bus.instr_valida, bus.detenido, bus.direccion, bus.instr_contadas} !== {1'b0, 1'b0, 10'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL rst_mid_after k%0d: got v=%b det=%b dir=%0d cnt=%0d want 0 0 0 0", k, bus.instr_valida, bus.detenido, bus.direccion, bus.instr_contadas);
      end
      go(0, 0, 0, 10'd0);
      n_cmp++;
      if ({bus.instr_valida, bus.pc_if, bus.instruccion_if} !== {1'b1, 10'd0, 32'h8C010001}) begin
        n_fail++;
        $display("FAIL rst_mid_first k%0d: got v=%b pc=%0d instr=%h want 1 0 8c010001", k, bus.instr_valida, bus.pc_if, bus.instruccion_if);
      end
    end
  endtask
  task automatic test_aleatorio();
    for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 15) == 0) ? HLT : $urandom;
    go(1, 0, 0, 10'd0);
    for (int c = 0; c < 3000; c++) begin
      go($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8, 10'($urandom));
      n_cmp++;
      if (obs() !== expd()) begin
        n_fail++;
        $display("FAIL random c%0d: got %h want %h", c, obs(), expd());
      end
    end
  endtask
  initial begin
    n_cmp = 0;
    n_fail = 0;
    started = 1'b0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.salto_tomado = 1'b0;
    bus.destino_salto = 10'd0;
    cargar_secuencia();
    test_reset();
    test_secuencia();
    test_stall();
    test_salto();
    test_salto_stall();
    test_wrap();
    test_reset_mid();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/unidad_de_busqueda.md
Name: unidad_de_busqueda

Overview:
- Fetch-stage controller for the pipeline: owns the program counter and drives the address into the synchronous-read instruction ROM (10-bit word address, 32-bit word, data valid one cycle after the address edge).
- Presents the fetched word, its PC and PC+1 to the IF/ID register with a valid flag.
- Handles HDU stalls, taken jump/branch redirects from ID, and halt on HLT (32'h00000000).

Parameters:
ANCHO_PC, 10, PC/word-address width; wraps modulo 2^ANCHO_PC
DIR_RESET, 0, PC value loaded on reset
INSTR_NOP, 32'h00000020, word driven on instruccion_if when not valid (ADD 0,0,0)
INSTR_HLT, 32'h00000000, opcode word that halts fetch

Ports:
clk  in  1  rising-edge clock shared with the instruction ROM
reset  in  1  synchronous, active-high
stall  in  1  HDU stall: hold PC and IF contents
salto_tomado  in  1  jump/branch taken, resolved in ID
destino_salto  in  ANCHO_PC  redirect target
instruccion_mem  in  32  ROM read data (word addressed last edge)
direccion  out  ANCHO_PC  ROM address
instruccion_if  out  32  word to IF/ID (INSTR_NOP when invalid)
pc_if  out  ANCHO_PC  address of instruccion_if
pc_mas_uno  out  ANCHO_PC  pc_if+1, wrapped
instr_valida  out  1  instruccion_if is a real instruction for IF/ID
detenido  out  1  halted
instr_contadas  out  32  instructions accepted by IF/ID since reset

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- State registers:
  - pc: next address to fetch.
  - pc_f: address of the word currently on instruccion_mem.
  - v_f: word on instruccion_mem is wanted.
  - halt flag.
  - instr_contadas.
- Reset (at sampled edge): pc=DIR_RESET, pc_f=DIR_RESET, v_f=0, halt=0, instr_contadas=0. While reset is held, direccion=DIR_RESET and instr_valida=0. Reset mid-run discards everything, including a pending redirect or halt.
- Combinational outputs:
  - direccion = (stall & ~salto_tomado) ? pc_f : pc. During a stall, pc_f is re-read so the ROM output is preserved.
  - instr_valida = v_f & ~salto_tomado & ~halt & ~reset.
  - instruccion_if = instr_valida ? instruccion_mem : INSTR_NOP.
  - pc_if = pc_f; pc_mas_uno = pc_f+1 mod 2^ANCHO_PC.
  - detenido = halt.
- Edge priority (highest first): reset > halt held > salto_tomado > stall > halt detect > normal.
  - halt held: all state frozen until reset.
  - salto_tomado: pc<=destino_salto, v_f<=0; pc_f don't-care; stall ignored.
    - The word currently in IF is flushed (instr_valida=0 this cycle), and the word fetched at this edge is invalidated.
    - Penalty is exactly 2 bubbles; rom[destino] is valid 2 cycles after the salto cycle.
  - stall (no salto): pc, pc_f, v_f hold; ROM re-reads pc_f; no count increment; no halt detection.
  - halt detect: instr_valida & instruccion_mem==INSTR_HLT & ~stall → halt<=1, v_f<=0, pc holds. The HLT word itself is delivered valid and counted.
  - normal: pc_f<=pc, pc<=pc+1 (1023→0 wrap), v_f<=1.
- instr_contadas increments on every edge with instr_valida & ~stall, and wraps at 2^32.
- Latency: first reset-low cycle C0 addresses DIR_RESET with instr_valida=0. From C1, one instruction per cycle.
- salto_tomado with destino_salto==pc_f is legal and behaves identically to any other redirect.

Test Plan:
- Reset then ROM {8C010001,00231020,00441820,00622020, 0...}, no stall:
  - C0: valid=0.
  - C1..C4: pc_if=0..3 with those words, pc_mas_uno=1..4.
  - C5: HLT at pc_if=4, valid=1.
  - C6 onward: detenido=1, valid=0, instr_contadas=5.
- stall high for 2 cycles while pc_if=1 (00231020):
  - instruccion_if/pc_if stable at 1 for 3 cycles, direccion=1.
  - Next cycle pc_if=2; count unaffected by stalled cycles.
- ROM {00210820,08000000,...}, salto_tomado with destino_salto=0 in the cycle pc_if=2:
  - That cycle valid=0, next cycle valid=0.
  - Following cycle pc_if=0, 00210820.
- salto_tomado and stall both high with destino_salto=3:
  - Stall ignored; direccion=pc this cycle.
  - Next cycle direccion=3; rom[3] valid one cycle later.
- pc=1023 running: pc_if=1023 then pc_if=0, pc_mas_uno at 1023 = 0.
- Reset asserted during stall and during halt:
  - Next cycle: valid=0, detenido=0, direccion=0, instr_contadas=0.
  - rom[0] valid one cycle after reset release.
